// File: rtl/ami_app_seg_tlb_pkg.sv
// ---------------------------------------------------------------------------
// AMITypes : shared types for the AMI memory path.
//   AMIReq           - memory request travelling between app ports and the
//                      channel-interleave stage (valid, isWrite, addr, size).
//   AMIAPP_TLB_Entry - one virtual->physical segment with permission flags.
//   APP_TLB_STATE    - state of a per-application TLB.
//   AMI_TLB_CMD      - control command for the app TLB programming FSM.
//   AMI_TLB_FIELD    - entry field selector used while programming.
//   seg_translate    - relocates an address from a segment base to its PA.
// ---------------------------------------------------------------------------
package AMITypes;

   localparam int AMI_ADDR_WIDTH          = 64;
   localparam int AMI_MAX_APP_TLB_ENTRIES = 16;

   typedef struct packed {
      logic                      valid;
      logic                      isWrite;
      logic [AMI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                size;
   } AMIReq;

   typedef struct packed {
      logic                      valid;
      logic                      in_memory;
      logic                      writable;
      logic                      readable;
      logic [AMI_ADDR_WIDTH-1:0] va_start;
      logic [AMI_ADDR_WIDTH-1:0] va_end;
      logic [AMI_ADDR_WIDTH-1:0] size;
      logic [AMI_ADDR_WIDTH-1:0] pa;
   } AMIAPP_TLB_Entry;

   typedef enum logic [1:0] {
      DISABLED    = 2'd0,
      PROGRAMMING = 2'd1,
      ENABLED     = 2'd2
   } APP_TLB_STATE;

   typedef enum logic [1:0] {
      NOP        = 2'd0,
      BEGIN_PROG = 2'd1,
      COMMIT     = 2'd2,
      DISABLE    = 2'd3
   } AMI_TLB_CMD;

   typedef enum logic [1:0] {
      FIELD_VA_START = 2'd0,
      FIELD_VA_END   = 2'd1,
      FIELD_PA       = 2'd2,
      FIELD_FLAGS    = 2'd3
   } AMI_TLB_FIELD;

   // Relocation wraps modulo 2^AMI_ADDR_WIDTH.
   function automatic logic [AMI_ADDR_WIDTH-1:0] seg_translate(
      input logic [AMI_ADDR_WIDTH-1:0] addr,
      input logic [AMI_ADDR_WIDTH-1:0] va_start,
      input logic [AMI_ADDR_WIDTH-1:0] pa
   );
      return addr - va_start + pa;
   endfunction

endpackage

// File: rtl/ami_app_seg_tlb_match.sv
// ---------------------------------------------------------------------------
// ami_seg_match : combinational segment lookup.
//   entries  in  NUM_ENTRIES segment entries
//   addr     in  virtual address to look up
//   is_write in  request direction
//   hit      out some valid entry covers addr
//   perm_ok  out winning entry is in memory and grants the access
//   idx      out index of the winning (lowest-index) entry
// ---------------------------------------------------------------------------
module ami_seg_match
   import AMITypes::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  AMIAPP_TLB_Entry           entries [NUM_ENTRIES],
   input  logic [AMI_ADDR_WIDTH-1:0] addr,
   input  logic                      is_write,
   output logic                      hit,
   output logic                      perm_ok,
   output logic [IDX_W-1:0]          idx
);

   logic [NUM_ENTRIES-1:0] match_s;
   logic [NUM_ENTRIES-1:0] perm_s;

   // Per-entry range compare (va_end exclusive) and permission check.
   always_comb begin
      match_s = '0;
      perm_s  = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         // A zero-length segment has size 0 and can never match.
         match_s[i] = entries[i].valid && (entries[i].size != {AMI_ADDR_WIDTH{1'b0}}) &&
                      (addr >= entries[i].va_start) && (addr < entries[i].va_end);
         perm_s[i]  = entries[i].in_memory &&
                      (is_write ? entries[i].writable : entries[i].readable);
      end
   end

   // Priority encode: walk downwards so the lowest matching index is kept last.
   always_comb begin
      hit     = 1'b0;
      perm_ok = 1'b0;
      idx     = {IDX_W{1'b0}};
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         hit     = hit | match_s[i];
         idx     = match_s[i] ? IDX_W'(i) : idx;
         perm_ok = match_s[i] ? perm_s[i] : perm_ok;
      end
   end

endmodule

// File: rtl/ami_app_seg_tlb.sv
// ---------------------------------------------------------------------------
// ami_app_seg_tlb : per-application segment TLB with programming FSM and a
// single registered, back-pressured output stage.
//   clk, rst_n            clock, asynchronous active-low reset
//   ctrl_cmd              NOP / BEGIN_PROG / COMMIT / DISABLE
//   prog_valid/idx/field/data   entry-field writes (honoured in PROGRAMMING)
//   tlb_state             DISABLED / PROGRAMMING / ENABLED
//   req_in, req_in_ready  upstream request handshake
//   req_out, req_out_ready  translated request handshake
//   fault_valid/addr/is_write/sticky  fault reporting
// Optional: define AMI_TLB_PERF_CNT_EN to add saturating 32-bit hit_cnt and
// fault_cnt outputs (cleared by BEGIN_PROG).
// ---------------------------------------------------------------------------
module ami_app_seg_tlb
   import AMITypes::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int ADDR_W      = AMI_ADDR_WIDTH,
   parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        ctrl_cmd,
   input  logic              prog_valid,
   input  logic [IDX_W-1:0]  prog_idx,
   input  logic [1:0]        prog_field,
   input  logic [ADDR_W-1:0] prog_data,
   output logic [1:0]        tlb_state,
   input  AMIReq             req_in,
   output logic              req_in_ready,
   output AMIReq             req_out,
   input  logic              req_out_ready,
   output logic              fault_valid,
   output logic [ADDR_W-1:0] fault_addr,
   output logic              fault_is_write,
`ifdef AMI_TLB_PERF_CNT_EN
   output logic [31:0]       hit_cnt,
   output logic [31:0]       fault_cnt,
`endif
   output logic              fault_sticky
);

   AMI_TLB_CMD      cmd_s;
   AMI_TLB_FIELD    field_s;
   APP_TLB_STATE    state_q, state_d;
   AMIAPP_TLB_Entry entries_q [NUM_ENTRIES];
   AMIAPP_TLB_Entry entries_d [NUM_ENTRIES];
   AMIAPP_TLB_Entry win_s;
   AMIReq           out_q, out_d;
   logic            fault_valid_q, fault_valid_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
   logic            fault_is_write_q, fault_is_write_d;
   logic            fault_sticky_q, fault_sticky_d;
   logic            hit_s, perm_ok_s, good_s, accept_s, fault_s, ready_s;
   logic [IDX_W-1:0] idx_s;

   assign cmd_s    = AMI_TLB_CMD'(ctrl_cmd);
   assign field_s  = AMI_TLB_FIELD'(prog_field);
   assign ready_s  = (state_q == ENABLED) && (!out_q.valid || req_out_ready);
   assign accept_s = req_in.valid && ready_s;
   assign good_s   = hit_s && perm_ok_s;
   assign fault_s  = accept_s && !good_s;

   ami_seg_match #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .IDX_W       (IDX_W)
   ) u_match (
      .entries  (entries_q),
      .addr     (req_in.addr),
      .is_write (req_in.isWrite),
      .hit      (hit_s),
      .perm_ok  (perm_ok_s),
      .idx      (idx_s)
   );

   // Select the winning entry for relocation.
   always_comb begin
      win_s = entries_q[0];
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         win_s = (idx_s == IDX_W'(i)) ? entries_q[i] : win_s;
      end
   end

   // Programming FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DISABLED:    state_d = (cmd_s == BEGIN_PROG) ? PROGRAMMING : DISABLED;
         PROGRAMMING: begin
            if (cmd_s == COMMIT) begin
               state_d = ENABLED;
            end else if (cmd_s == DISABLE) begin
               state_d = DISABLED;
            end else begin
               state_d = PROGRAMMING;
            end
         end
         ENABLED: begin
            if (cmd_s == BEGIN_PROG) begin
               state_d = PROGRAMMING;
            end else if (cmd_s == DISABLE) begin
               state_d = DISABLED;
            end else begin
               state_d = ENABLED;
            end
         end
         default:     state_d = DISABLED;
      endcase
   end

   // Entry table update: field writes, then DISABLE invalidation on top.
   always_comb begin
      entries_d = entries_q;
      if ((state_q == PROGRAMMING) && prog_valid) begin
         // Out-of-range indices match no entry and are dropped.
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (prog_idx == IDX_W'(i)) begin
               entries_d[i].valid = 1'b1;
               case (field_s)
                  FIELD_VA_START: begin
                     entries_d[i].va_start = prog_data;
                     entries_d[i].size     = entries_q[i].va_end - prog_data;
                  end
                  FIELD_VA_END: begin
                     entries_d[i].va_end = prog_data;
                     entries_d[i].size   = prog_data - entries_q[i].va_start;
                  end
                  FIELD_PA:    entries_d[i].pa = prog_data;
                  FIELD_FLAGS: {entries_d[i].in_memory, entries_d[i].writable,
                                entries_d[i].readable} = prog_data[2:0];
                  default:     entries_d[i].pa = entries_q[i].pa;
               endcase
            end else begin
               entries_d[i] = entries_q[i];
            end
         end
      end else begin
         entries_d = entries_q;
      end
      if (cmd_s == DISABLE) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entries_d[i].valid = 1'b0;
         end
      end else begin
         entries_d = entries_d;
      end
   end

   // Output register: load on a good accept, otherwise drain when taken.
   always_comb begin
      out_d = out_q;
      if (accept_s && good_s) begin
         out_d       = req_in;
         out_d.valid = 1'b1;
         out_d.addr  = seg_translate(req_in.addr, win_s.va_start, win_s.pa);
      end else if (req_out_ready) begin
         out_d.valid = 1'b0;
      end else begin
         out_d = out_q;
      end
   end

   // Fault capture; a clearing command overrides the sticky set.
   always_comb begin
      fault_valid_d    = fault_s;
      fault_addr_d     = fault_addr_q;
      fault_is_write_d = fault_is_write_q;
      fault_sticky_d   = fault_sticky_q;
      if (fault_s) begin
         fault_addr_d     = req_in.addr;
         fault_is_write_d = req_in.isWrite;
         fault_sticky_d   = 1'b1;
      end else begin
         fault_addr_d = fault_addr_q;
      end
      if ((cmd_s == BEGIN_PROG) || (cmd_s == DISABLE)) begin
         fault_sticky_d = 1'b0;
      end else begin
         fault_sticky_d = fault_sticky_d;
      end
   end

   // State, entry table, output stage and fault registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DISABLED;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entries_q[i] <= '0;
         end
         out_q            <= '0;
         fault_valid_q    <= 1'b0;
         fault_addr_q     <= {ADDR_W{1'b0}};
         fault_is_write_q <= 1'b0;
         fault_sticky_q   <= 1'b0;
      end else begin
         state_q          <= state_d;
         entries_q        <= entries_d;
         out_q            <= out_d;
         fault_valid_q    <= fault_valid_d;
         fault_addr_q     <= fault_addr_d;
         fault_is_write_q <= fault_is_write_d;
         fault_sticky_q   <= fault_sticky_d;
      end
   end

`ifdef AMI_TLB_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, fault_cnt_q, fault_cnt_d;

   // Saturating outcome counters, cleared by BEGIN_PROG.
   always_comb begin
      hit_cnt_d   = hit_cnt_q;
      fault_cnt_d = fault_cnt_q;
      if (cmd_s == BEGIN_PROG) begin
         hit_cnt_d   = 32'd0;
         fault_cnt_d = 32'd0;
      end else begin
         if (accept_s && good_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
         end else begin
            hit_cnt_d = hit_cnt_q;
         end
         if (fault_s && (fault_cnt_q != 32'hFFFF_FFFF)) begin
            fault_cnt_d = fault_cnt_q + 32'd1;
         end else begin
            fault_cnt_d = fault_cnt_q;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q   <= 32'd0;
         fault_cnt_q <= 32'd0;
      end else begin
         hit_cnt_q   <= hit_cnt_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   assign hit_cnt   = hit_cnt_q;
   assign fault_cnt = fault_cnt_q;
`endif

   assign tlb_state      = state_q;
   assign req_in_ready   = ready_s;
   assign req_out        = out_q;
   assign fault_valid    = fault_valid_q;
   assign fault_addr     = fault_addr_q;
   assign fault_is_write = fault_is_write_q;
   assign fault_sticky   = fault_sticky_q;

endmodule

// File: tb/tb_ami_app_seg_tlb.sv
// ---------------------------------------------------------------------------
// Bench for ami_app_seg_tlb: directed stimulus, a behavioural model of the
// TLB checked against the DUT every cycle, plus literal expectations.
// ---------------------------------------------------------------------------
module tb_ami_app_seg_tlb;
   import AMITypes::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  ctrl_cmd;
   logic        prog_valid;
   logic [1:0]  prog_idx;
   logic [1:0]  prog_field;
   logic [63:0] prog_data;
   logic [1:0]  tlb_state;
   AMIReq       req_in, req_out;
   logic        req_in_ready, req_out_ready;
   logic        fault_valid;
   logic [63:0] fault_addr;
   logic        fault_is_write, fault_sticky;
`ifdef AMI_TLB_PERF_CNT_EN
   logic [31:0] hit_cnt, fault_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ami_app_seg_tlb #(.NUM_ENTRIES(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ctrl_cmd       (ctrl_cmd),
      .prog_valid     (prog_valid),
      .prog_idx       (prog_idx),
      .prog_field     (prog_field),
      .prog_data      (prog_data),
      .tlb_state      (tlb_state),
      .req_in         (req_in),
      .req_in_ready   (req_in_ready),
      .req_out        (req_out),
      .req_out_ready  (req_out_ready),
      .fault_valid    (fault_valid),
      .fault_addr     (fault_addr),
      .fault_is_write (fault_is_write),
`ifdef AMI_TLB_PERF_CNT_EN
      .hit_cnt        (hit_cnt),
      .fault_cnt      (fault_cnt),
`endif
      .fault_sticky   (fault_sticky)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_state;
   logic        m_v  [4];
   logic [63:0] m_vs [4];
   logic [63:0] m_ve [4];
   logic [63:0] m_pa [4];
   logic [2:0]  m_fl [4];   // {in_memory, writable, readable}
   logic        m_out_valid, m_out_w;
   logic [63:0] m_out_addr;
   logic [7:0]  m_out_sz;
   logic        m_fv, m_fw, m_fs;
   logic [63:0] m_fa;
   logic [31:0] m_hc, m_fc;

   // First covering segment decides; returns {allowed, physical address}.
   function automatic logic [64:0] lookup(input logic [63:0] a, input logic w);
      for (int i = 0; i < 4; i++) begin
         if (m_v[i] && (m_vs[i] <= a) && (a < m_ve[i])) begin
            return {m_fl[i][2] && (w ? m_fl[i][1] : m_fl[i][0]), a - m_vs[i] + m_pa[i]};
         end
      end
      return {1'b0, 64'h0};
   endfunction

   wire        m_rdy = (m_state == 2) && (!m_out_valid || req_out_ready);
   wire        m_acc = req_in.valid && m_rdy;
   wire [64:0] m_lk  = lookup(req_in.addr, req_in.isWrite);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         for (int i = 0; i < 4; i++) m_v[i] <= 1'b0;
         m_out_valid <= 1'b0;
         m_fv <= 1'b0; m_fa <= 64'h0; m_fw <= 1'b0; m_fs <= 1'b0;
         m_hc <= 32'd0; m_fc <= 32'd0;
      end else begin
         if (ctrl_cmd == 2'd1) m_state <= 1;
         else if (ctrl_cmd == 2'd2 && m_state == 1) m_state <= 2;
         else if (ctrl_cmd == 2'd3) m_state <= 0;
         if (m_state == 1 && prog_valid) begin
            m_v[prog_idx] <= 1'b1;
            case (prog_field)
               2'd0:    m_vs[prog_idx] <= prog_data;
               2'd1:    m_ve[prog_idx] <= prog_data;
               2'd2:    m_pa[prog_idx] <= prog_data;
               default: m_fl[prog_idx] <= prog_data[2:0];
            endcase
         end
         if (ctrl_cmd == 2'd3) for (int i = 0; i < 4; i++) m_v[i] <= 1'b0;
         if (m_acc && m_lk[64]) begin
            m_out_valid <= 1'b1;
            m_out_addr  <= m_lk[63:0];
            m_out_w     <= req_in.isWrite;
            m_out_sz    <= req_in.size;
         end else if (req_out_ready) begin
            m_out_valid <= 1'b0;
         end
         m_fv <= m_acc && !m_lk[64];
         if (m_acc && !m_lk[64]) begin
            m_fa <= req_in.addr;
            m_fw <= req_in.isWrite;
         end
         if (ctrl_cmd == 2'd1 || ctrl_cmd == 2'd3) m_fs <= 1'b0;
         else if (m_acc && !m_lk[64]) m_fs <= 1'b1;
         if (ctrl_cmd == 2'd1) begin
            m_hc <= 32'd0; m_fc <= 32'd0;
         end else begin
            if (m_acc && m_lk[64] && m_hc != 32'hFFFF_FFFF) m_hc <= m_hc + 32'd1;
            if (m_acc && !m_lk[64] && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 32'd1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("state", {62'd0, tlb_state}, 64'(m_state));
      chk("in_ready", {63'd0, req_in_ready}, {63'd0, m_rdy});
      chk("out_valid", {63'd0, req_out.valid}, {63'd0, m_out_valid});
      if (m_out_valid) begin
         chk("out_addr", req_out.addr, m_out_addr);
         chk("out_write", {63'd0, req_out.isWrite}, {63'd0, m_out_w});
         chk("out_size", {56'd0, req_out.size}, {56'd0, m_out_sz});
      end
      chk("fault_valid", {63'd0, fault_valid}, {63'd0, m_fv});
      chk("fault_addr", fault_addr, m_fa);
      chk("fault_is_write", {63'd0, fault_is_write}, {63'd0, m_fw});
      chk("fault_sticky", {63'd0, fault_sticky}, {63'd0, m_fs});
`ifdef AMI_TLB_PERF_CNT_EN
      chk("hit_cnt", {32'd0, hit_cnt}, {32'd0, m_hc});
      chk("fault_cnt", {32'd0, fault_cnt}, {32'd0, m_fc});
`endif
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic cmd(input logic [1:0] c);
      ctrl_cmd = c;
      tick();
      ctrl_cmd = 2'd0;
   endtask

   task automatic prog(input logic [1:0] i, input logic [1:0] f, input logic [63:0] d);
      prog_valid = 1'b1; prog_idx = i; prog_field = f; prog_data = d;
      tick();
      prog_valid = 1'b0;
   endtask

   task automatic entry(input logic [1:0] i, input logic [63:0] vs, input logic [63:0] ve,
                        input logic [63:0] pa, input logic [63:0] fl);
      prog(i, 2'd0, vs);
      prog(i, 2'd1, ve);
      prog(i, 2'd2, pa);
      prog(i, 2'd3, fl);
   endtask

   // Present a request and hold it until accepted (bounded).
   task automatic send(input logic [63:0] a, input logic w, input logic [7:0] sz);
      int n;
      req_in.valid = 1'b1; req_in.addr = a; req_in.isWrite = w; req_in.size = sz;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (req_in_ready) break;
         n++;
      end
      if (n >= 20) begin
         total++; bad++;
         $display("FAIL send_timeout actual=no_accept required=accept addr=%h", a);
      end
      tick();
      req_in.valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ctrl_cmd = 2'd0; prog_valid = 1'b0; prog_idx = 2'd0;
      prog_field = 2'd0; prog_data = 64'd0; req_in = '0; req_out_ready = 1'b1;
      tick(); tick();
      chk("rst_state", {62'd0, tlb_state}, 64'd0);
      chk("rst_in_ready", {63'd0, req_in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, req_out.valid}, 64'd0);
      chk("rst_sticky", {63'd0, fault_sticky}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic translation and priority.
      cmd(2'd1);
      entry(2'd0, 64'h1000, 64'h2000, 64'h8000_0000, 64'd7);
      entry(2'd1, 64'h1800, 64'h3000, 64'h9000_0000, 64'd7);
      cmd(2'd2);
      send(64'h1040, 1'b0, 8'h10);
      chk("t1_valid", {63'd0, req_out.valid}, 64'd1);
      chk("t1_addr", req_out.addr, 64'h8000_0040);
      chk("t1_size", {56'd0, req_out.size}, 64'h10);
      send(64'h1800, 1'b1, 8'h20);
      chk("prio_addr", req_out.addr, 64'h8000_0800);
      chk("prio_write", {63'd0, req_out.isWrite}, 64'd1);

      // Read-only entry0, zero-length entry1.
      cmd(2'd1);
      prog(2'd0, 2'd3, 64'd5);
      prog(2'd1, 2'd1, 64'h1800);
      cmd(2'd2);
      send(64'h1000, 1'b1, 8'h4);
      chk("wr_fault_pulse", {63'd0, fault_valid}, 64'd1);
      chk("wr_fault_addr", fault_addr, 64'h1000);
      chk("wr_fault_is_write", {63'd0, fault_is_write}, 64'd1);
      chk("wr_fault_sticky", {63'd0, fault_sticky}, 64'd1);
      chk("wr_no_out", {63'd0, req_out.valid}, 64'd0);
      send(64'h1FFF, 1'b0, 8'h1);
      chk("edge_hit", req_out.addr, 64'h8000_0FFF);
      send(64'h2000, 1'b0, 8'h1);
      chk("end_excl_fault", {63'd0, fault_valid}, 64'd1);
      chk("end_excl_addr", fault_addr, 64'h2000);
      send(64'h1800, 1'b0, 8'h1);
      chk("zero_len_hit_e0", req_out.addr, 64'h8000_0800);
      send(64'h2800, 1'b0, 8'h1);
      chk("zero_len_fault", {63'd0, fault_valid}, 64'd1);

      // Back-pressure.
      req_out_ready = 1'b0;
      req_in.valid = 1'b1; req_in.addr = 64'h1100; req_in.isWrite = 1'b0; req_in.size = 8'h8;
      tick();
      req_in.addr = 64'h1200;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_addr", req_out.addr, 64'h8000_0100);
         chk("bp_in_ready", {63'd0, req_in_ready}, 64'd0);
      end
      req_out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", {63'd0, req_in_ready}, 64'd1);
      tick();
      req_in.valid = 1'b0;
      chk("bp_next_addr", req_out.addr, 64'h8000_0200);

      // Accept together with BEGIN_PROG.
      req_in.valid = 1'b1; req_in.addr = 64'h1300;
      ctrl_cmd = 2'd1;
      tick();
      req_in.valid = 1'b0; ctrl_cmd = 2'd0;
      chk("bp_cmd_state", {62'd0, tlb_state}, 64'd1);
      chk("bp_cmd_out", req_out.addr, 64'h8000_0300);
      chk("bp_cmd_ready", {63'd0, req_in_ready}, 64'd0);
      chk("bp_cmd_sticky", {63'd0, fault_sticky}, 64'd0);
      entry(2'd2, 64'h4000, 64'h5000, 64'hA000_0000, 64'd7);
      cmd(2'd2);
      send(64'h4010, 1'b1, 8'h8);
      chk("e2_addr", req_out.addr, 64'hA000_0010);

      // DISABLE invalidates everything.
      cmd(2'd3);
      chk("dis_state", {62'd0, tlb_state}, 64'd0);
      cmd(2'd1);
      cmd(2'd2);
      send(64'h4010, 1'b0, 8'h8);
      chk("dis_fault", {63'd0, fault_valid}, 64'd1);

      // Fault together with BEGIN_PROG: pulse kept, sticky cleared.
      req_in.valid = 1'b1; req_in.addr = 64'h1000; req_in.isWrite = 1'b0;
      ctrl_cmd = 2'd1;
      tick();
      req_in.valid = 1'b0; ctrl_cmd = 2'd0;
      chk("fp_pulse", {63'd0, fault_valid}, 64'd1);
      chk("fp_sticky", {63'd0, fault_sticky}, 64'd0);

      // Asynchronous reset while output is held.
      entry(2'd0, 64'h1000, 64'h2000, 64'h8000_0000, 64'd7);
      cmd(2'd2);
      req_out_ready = 1'b0;
      send(64'h1010, 1'b0, 8'h2);
      chk("mid_held", {63'd0, req_out.valid}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_out", {63'd0, req_out.valid}, 64'd0);
      chk("mid_rst_state", {62'd0, tlb_state}, 64'd0);
      tick();
      rst_n = 1'b1; req_out_ready = 1'b1;
      tick();

`ifdef AMI_TLB_PERF_CNT_EN
      cmd(2'd1);
      entry(2'd0, 64'h1000, 64'h2000, 64'h8000_0000, 64'd7);
      cmd(2'd2);
      send(64'h1000, 1'b0, 8'h1);
      send(64'h1100, 1'b1, 8'h1);
      send(64'h1200, 1'b0, 8'h1);
      send(64'h5000, 1'b0, 8'h1);
      send(64'h6000, 1'b1, 8'h1);
      chk("perf_hits", {32'd0, hit_cnt}, 64'd3);
      chk("perf_faults", {32'd0, fault_cnt}, 64'd2);
      cmd(2'd1);
      chk("perf_clr_hits", {32'd0, hit_cnt}, 64'd0);
      chk("perf_clr_faults", {32'd0, fault_cnt}, 64'd0);
`endif

      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
